// File: rtl/mesh_term_ingress.sv
// Terminal-to-mesh ingress buffer: circular FIFO with first-word-fall-through head.
// Optional MESH_ADDR_CHECK_EN rejects non-broadcast pushes addressed outside the mesh.
module mesh_term_ingress #(
  parameter int          PCKG_SZ    = 40,
  parameter int          FIFO_DEPTH = 4,
  parameter int          ROWS       = 4,
  parameter int          COLUMS     = 4,
  parameter logic [7:0]  BDCST      = 8'hFF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [PCKG_SZ-1:0]                data_in,
  input  logic                              popin,
  output logic                              pndng,
  output logic [PCKG_SZ-1:0]                data_out,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              bdcst_head,
  output logic                              ovf,
  output logic                              udf,
  output logic [15:0]                       drop_cnt,
  output logic                              err_addr
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef MESH_ADDR_CHECK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif

  logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wptr, rptr;
  logic [PCKG_SZ-1:0] head;
  logic [3:0]         hrow, hcol;
  logic               range_bad, addr_bad, wr, rd, drop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign hrow      = data_in[PCKG_SZ-9:PCKG_SZ-12];
  assign hcol      = data_in[PCKG_SZ-13:PCKG_SZ-16];
  assign range_bad = (int'(hrow) > ROWS+1) || (int'(hcol) > COLUMS+1);
  // broadcasts bypass the range check
  assign addr_bad  = ADDR_CHK && (data_in[PCKG_SZ-1:PCKG_SZ-8] != BDCST) && range_bad;

  assign pndng      = (count != '0);
  assign full       = (count == ($clog2(FIFO_DEPTH+1))'(FIFO_DEPTH));
  assign head       = mem[rptr];
  assign data_out   = pndng ? head : '0;
  assign bdcst_head = pndng && (head[PCKG_SZ-1:PCKG_SZ-8] == BDCST);

  // a pop in the same cycle frees the slot, so a full buffer still accepts
  assign rd   = popin && pndng;
  assign wr   = push && !addr_bad && (!full || popin);
  assign drop = push && !wr;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      drop_cnt <= '0;
      err_addr <= 1'b0;
    end else begin
      err_addr <= push && addr_bad;
      if (wr) wptr <= nxt(wptr);
      if (rd) rptr <= nxt(rptr);
      if (wr && !rd)      count <= count + 1'b1;
      else if (rd && !wr) count <= count - 1'b1;
      if (push && full && !popin) ovf <= 1'b1;
      if (popin && !pndng)        udf <= 1'b1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule

// File: doc/mesh_term_ingress.md
MESH_TERM_INGRESS -- requirements
Module: mesh_term_ingress

Interface
REQ-001 SHALL have parameter PCKG_SZ, default 40, packet width in bits (min 24).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries in the buffer (any integer >= 2, not restricted to powers of 2).
REQ-003 SHALL have parameter ROWS, default 4, mesh rows.
REQ-004 SHALL have parameter COLUMS, default 4, mesh columns.
REQ-005 SHALL have parameter BDCST, default 8'hFF, broadcast value of the Nxtjp field.
REQ-006 Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write request from the terminal.
- data_in  input  PCKG_SZ  packet to write.
- popin  input  1  router pop of the head packet.
- pndng  output  1  head packet valid (buffer not empty).
- data_out  output  PCKG_SZ  head packet; first-word-fall-through.
- full  output  1  count == FIFO_DEPTH.
- count  output  $clog2(FIFO_DEPTH+1)  occupancy.
- bdcst_head  output  1  head Nxtjp field [PCKG_SZ-1:PCKG_SZ-8] == BDCST, qualified by pndng.
- ovf  output  1  sticky: a push was dropped.
- udf  output  1  sticky: popin while empty.
- drop_cnt  output  16  count of dropped pushes, saturating.
- err_addr  output  1  one-cycle pulse on an address-rejected push.

Function
REQ-007 Header fields SHALL be: Nxtjp [PCKG_SZ-1:PCKG_SZ-8], row [PCKG_SZ-9:PCKG_SZ-12], column [PCKG_SZ-13:PCKG_SZ-16], mode [PCKG_SZ-17], payload [PCKG_SZ-18:0].
REQ-008 Storage SHALL be a circular buffer with read and write pointers that wrap from FIFO_DEPTH-1 to 0.
REQ-009 A push while not full SHALL write data_in at the write pointer and increment count.
REQ-010 data_out SHALL present the head entry combinationally from the registered read pointer; pndng SHALL rise the cycle after the first accepted push (write-to-read latency 1 cycle).
REQ-011 popin with pndng=1 SHALL advance the read pointer and decrement count.
REQ-012 popin with pndng=0 SHALL leave state unchanged and set udf.
REQ-013 Push while full without popin SHALL discard data_in, set ovf, and increment drop_cnt.
REQ-014 Push and popin in the same cycle while full SHALL both succeed; count stays FIFO_DEPTH and ovf is not set.
REQ-015 Push and popin in the same cycle while empty SHALL accept the push; udf is set; count becomes 1.
REQ-016 Push and popin in the same cycle, 0<count<FIFO_DEPTH, SHALL leave count unchanged and advance both pointers.
REQ-017 drop_cnt SHALL saturate at 16'hFFFF.
REQ-018 data_out SHALL be all zeros when pndng=0.
REQ-019 Once set, ovf and udf SHALL hold until reset.

Reset
REQ-020 reset=1 at a rising edge SHALL clear pointers, count, ovf, udf, drop_cnt, and err_addr, giving pndng=0, full=0, bdcst_head=0, data_out=0.
REQ-021 reset SHALL take priority over push/popin in the same cycle; buffer contents need not be cleared.
REQ-022 Reset asserted mid-operation SHALL discard all held packets; the first push after deassertion is the next head.

Configuration
REQ-023 With macro MESH_ADDR_CHECK_EN defined, a non-broadcast push with row > ROWS+1 or column > COLUMS+1 SHALL be discarded: err_addr pulses for 1 cycle and drop_cnt increments; ovf is not set.
REQ-024 With MESH_ADDR_CHECK_EN defined, a push that is both full-dropped and address-invalid SHALL increment drop_cnt once and set both ovf and err_addr.
REQ-025 Without MESH_ADDR_CHECK_EN, all pushes SHALL be subject only to the full check, and err_addr SHALL be tied to 0.

Verification
REQ-026 Reset, then push 40'h00_20_8_00001 (row 2, column 0, mode 1) -> next cycle pndng=1, data_out equals the pushed packet, count=1, bdcst_head=0.
REQ-027 Push 5 packets with FIFO_DEPTH=4 and no pop -> full=1 after the 4th; the 5th is dropped; ovf=1, drop_cnt=1; pops return packets 1-4 in order.
REQ-028 Full buffer, push and popin together for 10 cycles -> count stays 4, no drops, output order preserved across pointer wrap.
REQ-029 popin on empty -> udf=1, count=0; push with Nxtjp=8'hFF -> bdcst_head=1.
REQ-030 MESH_ADDR_CHECK_EN defined, push with row=4'hF, Nxtjp=0 -> err_addr pulses, count unchanged, drop_cnt+1; same packet with Nxtjp=8'hFF is accepted.
REQ-031 Reset asserted with 3 packets held -> next cycle pndng=0, count=0, drop_cnt=0, ovf=0.
